core_mutex_bank: RTL and testbench
==================================

# core_mutex_bank

Parametrised hardware mutex bank for multi-core Nios II systems: NUM_MUTEX independent owner/value mutexes behind one Avalon-MM slave, with per-mutex lease timeout (auto-release of abandoned locks), sticky expiry flags and an interrupt. Sits on the shared system interconnect between cores. Generalises the single-mutex block: N channels, configurable field widths, registered read data, lease/expiry behaviour.

## Interface
- NUM_MUTEX, 8: number of mutexes, 1..16.
- OWNER_W, 16: owner field width, 1..16; data bits [16+OWNER_W-1:16].
- VALUE_W, 16: value field width, 1..16; data bits [VALUE_W-1:0].
- TIMEOUT_W, 16: lease counter / timeout register width, 1..32.
- INIT_TIMEOUT, 0: reset value of timeout register; 0 = leasing disabled.

- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  5  word address (map below).
- chipselect  input  1  slave select.
- read  input  1  read strobe, qualified by chipselect.
- write  input  1  write strobe, qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  read data, registered, latency 1.
- irq  output  1  level interrupt: (expired flags != 0) & irq_enable.

## Operation
- Address map: 0..15 mutex i (bits [31:16] owner, [15:0] value); 16 reset_reg; 17 timeout; 18 status; 19 irq_enable (bit 0). Mutex addresses >= NUM_MUTEX and addresses 20..31: read 0, writes ignored.
- Unused field bits (above OWNER_W/VALUE_W) read 0, ignored in compares.
- Mutex write (address i < NUM_MUTEX): accepted iff value_i == 0 or owner_i == writedata owner field. Accepted: owner_i, value_i <= writedata fields. Rejected: no state change, no error. Writing value 0 with matching owner releases.
- Lease: accepted write with nonzero value loads lease_i <= timeout (current register value). Timeout register writes do not affect running leases.
- While value_i != 0 and lease_i != 0: lease_i > 1 decrements each cycle; lease_i == 1 at an edge auto-releases: value_i, owner_i, lease_i <= 0 and expired_i <= 1.
- Lease loaded as 0 (timeout disabled): mutex never expires.
- Release (value 0 write) clears lease_i.
- Status read: [15:0] expired flags, [31:16] held bitmap (value_i != 0); bits >= NUM_MUTEX read 0. Status write: write-1-to-clear on bits [15:0]; upper bits ignored.
- reset_reg: reads 1 after reset; any write clears to 0 (software first-boot detection).
- Timeout write: timeout <= writedata[TIMEOUT_W-1:0]; read returns it zero-extended.
- Simultaneous events:
  - write to mutex i on its expiry edge: write evaluated against pre-expiry state; if accepted it wins (fields and lease reloaded, expired_i not set); if rejected, expiry proceeds.
  - status W1C on same edge as new expiry of bit i: set wins, expired_i = 1.
  - read and write same cycle at same address: readdata shows pre-write value.

## Timing
- Reset (reset high at edge): all owner/value/lease = 0, expired = 0, timeout = INIT_TIMEOUT, irq_enable = 0, reset_reg = 1, readdata = 0, irq = 0. Reset mid-lease aborts it with no expired flag.
- Writes take effect at the edge where chipselect & write; zero wait states.
- Read: chipselect & read at edge k -> readdata valid after edge k, held until next read; not updated otherwise.
- Lease: acquiring write at edge k with timeout T > 0 -> held after edges k..k+T-1, released (and expired_i set) at edge k+T; irq high after edge k+T if enabled.
- irq combinational from registered flags/enable; drops the cycle after W1C clear or enable cleared.

## Test plan
- Reset, read addr 16 -> 1; write 16, read -> 0; read mutex 0 -> 0x00000000; irq = 0.
- Write 0x0001_0005 to mutex 3, then 0x0002_0007 -> mutex 3 reads 0x0001_0005; write 0x0001_0000 -> reads 0x0001_0000, status[19] = 0; then 0x0002_0007 accepted.
- Timeout = 10, irq_enable = 1, acquire mutex 2 at edge k -> held through edge k+9, value 0 after edge k+10, status = 0x0000_0004, irq = 1; W1C 0x4 -> status 0, irq = 0.
- Timeout 10; owner rewrites mutex 2 at exact expiry edge -> stays held, lease reloaded to 10, no expired flag; foreign-owner write at expiry edge -> rejected, expired_2 set.
- NUM_MUTEX = 4: write to address 6 -> ignored, reads 0; status [31:20] and [15:4] read 0.
- Assert reset with mutexes 0,1 held and lease running -> all cleared, status 0, timeout back to INIT_TIMEOUT, no irq.

Source files
------------

// File: rtl/core_mutex_bank_if.sv
// Avalon-MM slave bus bundle between the interconnect and the mutex bank.
interface core_mutex_bank_if;
    logic [4:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, read, write, writedata, input readdata);
    modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/core_mutex_bank.sv
// Bank of owner/value hardware mutexes with per-mutex lease timeout, sticky
// expiry flags, first-boot flag and a level interrupt, behind one Avalon-MM slave.
module core_mutex_bank #(
    parameter int          NUM_MUTEX    = 8,
    parameter int          OWNER_W      = 16,
    parameter int          VALUE_W      = 16,
    parameter int          TIMEOUT_W    = 16,
    parameter int unsigned INIT_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    core_mutex_bank_if.slave bus,
    output logic             irq
);
    localparam logic [4:0] ADDR_RESET   = 5'd16;
    localparam logic [4:0] ADDR_TIMEOUT = 5'd17;
    localparam logic [4:0] ADDR_STATUS  = 5'd18;
    localparam logic [4:0] ADDR_IRQ_EN  = 5'd19;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_INIT = TIMEOUT_W'(INIT_TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] LEASE_ONE    = TIMEOUT_W'(1);

    logic [OWNER_W-1:0]   owner_q [NUM_MUTEX];
    logic [VALUE_W-1:0]   value_q [NUM_MUTEX];
    logic [TIMEOUT_W-1:0] lease_q [NUM_MUTEX];
    logic [NUM_MUTEX-1:0] expired_q;
    logic [NUM_MUTEX-1:0] held;
    logic [NUM_MUTEX-1:0] accept;
    logic [NUM_MUTEX-1:0] expire_now;
    logic [NUM_MUTEX-1:0] w1c_mask;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic                 irq_en_q;
    logic                 reset_reg_q;
    logic [31:0]          rd_data_p0;
    logic [31:0]          rd_data_p1;
    logic                 wr_en;
    logic                 rd_en;
    logic [OWNER_W-1:0]   wr_owner;
    logic [VALUE_W-1:0]   wr_value;
    logic                 unused_wdata;

    assign wr_en        = bus.chipselect & bus.write;
    assign rd_en        = bus.chipselect & bus.read;
    assign wr_owner     = bus.writedata[16 +: OWNER_W];
    assign wr_value     = bus.writedata[VALUE_W-1:0];
    assign unused_wdata = ^bus.writedata;
    assign w1c_mask     = (wr_en && bus.address == ADDR_STATUS) ? bus.writedata[NUM_MUTEX-1:0] : '0;

    // A write is judged against the pre-edge state, so an accepted write on
    // the expiry edge pre-empts the auto-release.
    always_comb begin
        held       = '0;
        accept     = '0;
        expire_now = '0;
        for (int i = 0; i < NUM_MUTEX; i++) begin
            held[i]       = (value_q[i] != '0);
            accept[i]     = wr_en && (bus.address == 5'(i)) &&
                            ((value_q[i] == '0) || (owner_q[i] == wr_owner));
            expire_now[i] = (value_q[i] != '0) && (lease_q[i] == LEASE_ONE);
        end
    end

    always_comb begin
        rd_data_p0 = '0;
        for (int i = 0; i < NUM_MUTEX; i++) begin
            if (bus.address == 5'(i)) begin
                rd_data_p0[16 +: OWNER_W]   = owner_q[i];
                rd_data_p0[VALUE_W-1:0]     = value_q[i];
            end
        end
        case (bus.address)
            ADDR_RESET:   rd_data_p0[0] = reset_reg_q;
            ADDR_TIMEOUT: rd_data_p0[TIMEOUT_W-1:0] = timeout_q;
            ADDR_STATUS: begin
                rd_data_p0[16 +: NUM_MUTEX]  = held;
                rd_data_p0[NUM_MUTEX-1:0]    = expired_q;
            end
            ADDR_IRQ_EN:  rd_data_p0[0] = irq_en_q;
            default: ;
        endcase
    end

    // Stage p0 -> p1: register state updates and the read-data word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_MUTEX; i++) begin
                owner_q[i] <= '0;
                value_q[i] <= '0;
                lease_q[i] <= '0;
            end
            expired_q   <= '0;
            timeout_q   <= TIMEOUT_INIT;
            irq_en_q    <= 1'b0;
            reset_reg_q <= 1'b1;
            rd_data_p1  <= '0;
        end else begin
            for (int i = 0; i < NUM_MUTEX; i++) begin
                if (accept[i]) begin
                    owner_q[i] <= wr_owner;
                    value_q[i] <= wr_value;
                    lease_q[i] <= (wr_value != '0) ? timeout_q : '0;
                end else if (expire_now[i]) begin
                    owner_q[i] <= '0;
                    value_q[i] <= '0;
                    lease_q[i] <= '0;
                end else if (held[i] && (lease_q[i] > LEASE_ONE)) begin
                    lease_q[i] <= lease_q[i] - LEASE_ONE;
                end
            end
            // A fresh expiry beats a same-edge clear of that flag.
            expired_q <= (expired_q & ~w1c_mask) | (expire_now & ~accept);
            if (wr_en && bus.address == ADDR_TIMEOUT) timeout_q <= bus.writedata[TIMEOUT_W-1:0];
            if (wr_en && bus.address == ADDR_IRQ_EN)  irq_en_q <= bus.writedata[0];
            if (wr_en && bus.address == ADDR_RESET)   reset_reg_q <= 1'b0;
            if (rd_en) rd_data_p1 <= rd_data_p0;
        end
    end

    assign bus.readdata = rd_data_p1;
    assign irq          = (|expired_q) & irq_en_q;
endmodule

// File: tb/tb_core_mutex_bank.sv
// Bench for core_mutex_bank: directed scenarios plus random traffic, all
// compared against a deadline-based behavioural model of the mutex bank.
module tb_core_mutex_bank;
    localparam int NM = 4;
    localparam int OW = 8;
    localparam int VW = 12;
    localparam int TW = 16;
    localparam int unsigned INIT_T = 0;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    int   checks   = 0;
    int   failures = 0;

    core_mutex_bank_if bus ();

    core_mutex_bank #(
        .NUM_MUTEX(NM), .OWNER_W(OW), .VALUE_W(VW), .TIMEOUT_W(TW), .INIT_TIMEOUT(INIT_T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: each held mutex has an absolute expiry edge number (0 = never).
    int unsigned  m_own [NM];
    int unsigned  m_val [NM];
    longint       m_dl  [NM];
    bit [NM-1:0]  m_exp;
    int unsigned  m_timeout;
    bit           m_irqen;
    bit           m_rstreg;
    logic [31:0]  m_rdata;
    longint       edge_no = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit m_irq();
        return (m_exp != '0) && m_irqen;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] r;
        r = '0;
        if (a < NM) r = (32'(m_own[a]) << 16) | 32'(m_val[a]);
        else if (a == 16) r = {31'b0, m_rstreg};
        else if (a == 17) r = 32'(m_timeout);
        else if (a == 18) begin
            for (int i = 0; i < NM; i++) if (m_val[i] != 0) r[16+i] = 1'b1;
            r[NM-1:0] = m_exp;
        end
        else if (a == 19) r = {31'b0, m_irqen};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            m_own[i] = 0;
            m_val[i] = 0;
            m_dl[i]  = 0;
        end
        m_exp     = '0;
        m_timeout = INIT_T;
        m_irqen   = 1'b0;
        m_rstreg  = 1'b1;
        m_rdata   = '0;
    endtask

    task automatic model_edge(input bit c, input bit r, input bit w, input int a, input logic [31:0] d);
        int unsigned wo;
        int unsigned wv;
        bit          acc;
        bit [NM-1:0] newexp;
        edge_no++;
        wo     = (d >> 16) & ((1 << OW) - 1);
        wv     = d & ((1 << VW) - 1);
        newexp = '0;
        if (c && r) m_rdata = model_read(a);
        acc = c && w && (a < NM) && ((m_val[a] == 0) || (m_own[a] == wo));
        for (int i = 0; i < NM; i++) begin
            if (acc && a == i) begin
                m_own[i] = wo;
                m_val[i] = wv;
                m_dl[i]  = (wv != 0 && m_timeout != 0) ? edge_no + longint'(m_timeout) : 0;
            end else if (m_val[i] != 0 && m_dl[i] == edge_no) begin
                m_own[i]  = 0;
                m_val[i]  = 0;
                m_dl[i]   = 0;
                newexp[i] = 1'b1;
            end
        end
        if (c && w && a == 18) m_exp = m_exp & ~d[NM-1:0];
        m_exp = m_exp | newexp;
        if (c && w && a == 17) m_timeout = 32'(d[TW-1:0]);
        if (c && w && a == 19) m_irqen = d[0];
        if (c && w && a == 16) m_rstreg = 1'b0;
    endtask

    task automatic cyc(input bit c, input bit r, input bit w, input int a, input logic [31:0] d);
        bus.chipselect = c;
        bus.read       = r;
        bus.write      = w;
        bus.address    = 5'(a);
        bus.writedata  = d;
        @(posedge clk);
        model_edge(c, r, w, a, d);
        #1;
        check("readdata", bus.readdata, m_rdata);
        check("irq", {31'b0, irq}, {31'b0, m_irq()});
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cyc(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd_exp(input int a, input logic [31:0] exp);
        cyc(1'b1, 1'b1, 1'b0, a, 32'h0);
        check($sformatf("rd_addr%0d", a), bus.readdata, exp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 0, 32'h0);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        @(posedge clk);
        edge_no++;
        model_reset();
        #1;
        reset = 1'b0;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        model_reset();

        // Reset state and first-boot flag
        do_reset();
        rd_exp(16, 32'h1);
        wr(16, 32'h0);
        rd_exp(16, 32'h0);
        rd_exp(0, 32'h0);

        // Ownership: foreign write rejected, owner release, then new owner
        wr(3, 32'h0001_0005);
        wr(3, 32'h0002_0007);
        rd_exp(3, 32'h0001_0005);
        wr(3, 32'h0001_0000);
        rd_exp(3, 32'h0001_0000);
        rd_exp(18, 32'h0);
        wr(3, 32'h0002_0007);
        rd_exp(3, 32'h0002_0007);
        wr(3, 32'h0002_0000);

        // Lease expiry exactly T edges after acquisition, irq and W1C
        wr(17, 32'd10);
        wr(19, 32'h1);
        wr(2, 32'h0001_0005);
        idle(9);
        rd_exp(2, 32'h0001_0005);
        rd_exp(2, 32'h0);
        rd_exp(18, 32'h0000_0004);
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(18, 32'h4);
        check("irq_clr", {31'b0, irq}, 32'h0);
        rd_exp(18, 32'h0);

        // Owner rewrite on the expiry edge wins; foreign write there loses
        wr(2, 32'h0001_0005);
        idle(9);
        wr(2, 32'h0001_0006);
        rd_exp(18, 32'h0004_0000);
        idle(8);
        wr(2, 32'h0003_0009);
        rd_exp(18, 32'h0000_0004);
        rd_exp(2, 32'h0);
        wr(18, 32'h4);

        // W1C on the same edge as a new expiry: flag stays set
        wr(2, 32'h0001_0005);
        idle(9);
        wr(18, 32'h4);
        rd_exp(18, 32'h0000_0004);
        wr(18, 32'h4);

        // Unimplemented mutex address and held bitmap width
        wr(17, 32'd0);
        wr(6, 32'h0001_0005);
        rd_exp(6, 32'h0);
        wr(0, 32'h0001_0005);
        wr(1, 32'h0002_0003);
        rd_exp(18, 32'h0003_0000);
        wr(17, 32'd20);
        wr(3, 32'h0004_0001);
        rd_exp(18, 32'h000B_0000);

        // Reset in the middle of a running lease
        do_reset();
        rd_exp(18, 32'h0);
        rd_exp(17, 32'h0);
        rd_exp(0, 32'h0);
        rd_exp(3, 32'h0);
        rd_exp(16, 32'h1);
        idle(25);
        rd_exp(18, 32'h0);
        check("irq_after_reset", {31'b0, irq}, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int          a;
            int          sel;
            logic [31:0] d;
            bit          c;
            bit          r;
            bit          w;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = $urandom_range(0, 3);
            else if (sel < 8) a = $urandom_range(16, 19);
            else              a = $urandom_range(0, 31);
            d[31:16] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(1, 3));
            d[15:0]  = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h1FFF));
            if (a == 17) d = 32'($urandom_range(0, 8));
            else if (a == 18 || a == 19) d = $urandom;
            c = ($urandom_range(0, 7) != 0);
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            cyc(c, r, w, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
